// File: rtl/ocimem_access_arbiter_if.sv
// Signal bundle between the OCI RAM arbiter, its two requesters (JTAG and Avalon) and the RAM.
// The arbiter connects through the slave modport; the environment driving it uses master.
interface ocimem_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              jtag_req;
  logic              jtag_wr;
  logic [ADDR_W-1:0] jtag_addr;
  logic [DATA_W-1:0] jtag_wdata;
  logic [DATA_W-1:0] jtag_rdata;
  logic              jtag_rdata_valid;
  logic              jtag_overrun;
  logic              clear_overrun;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  jtag_req, jtag_wr, jtag_addr, jtag_wdata, clear_overrun,
    input  avs_address, avs_read, avs_write, avs_writedata, ram_rdata,
    output jtag_rdata, jtag_rdata_valid, jtag_overrun,
    output avs_readdata, avs_waitrequest,
    output ram_addr, ram_wdata, ram_we, ram_re
  );

  modport master (
    output jtag_req, jtag_wr, jtag_addr, jtag_wdata, clear_overrun,
    output avs_address, avs_read, avs_write, avs_writedata, ram_rdata,
    input  jtag_rdata, jtag_rdata_valid, jtag_overrun,
    input  avs_readdata, avs_waitrequest,
    input  ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/ocimem_access_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path (J) and an Avalon-MM
// debug slave (A), one access at a time, with round-robin fairness on contention.
module ocimem_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ocimem_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, J_ACC, J_RD, A_ACC, A_RD} state_t;

  state_t            state_reg, state_next;
  logic              j_pend_reg;
  logic              hold_wr_reg;
  logic [ADDR_W-1:0] hold_addr_reg;
  logic [DATA_W-1:0] hold_wdata_reg;
  logic              last_grant_j_reg;
  logic [DATA_W-1:0] jtag_rdata_reg;
  logic              rdata_valid_reg;
  logic              overrun_reg;

  logic              a_pend;
  logic              j_contend;
  logic              j_clr;
  logic              j_accept;
  logic              j_drop;
  logic              grant_j;
  logic              grant_a;
  logic [ADDR_W-1:0] ram_addr_sel;
  logic [DATA_W-1:0] ram_wdata_sel;
  logic              ram_we_sel;
  logic              ram_re_sel;
  logic              waitrequest_sel;

  assign a_pend    = bus.avs_read | bus.avs_write;
  // A pulse still being captured counts as J contending, so J wins a tie that arrives
  // together with an Avalon request; the FSM waits one cycle for the holding register.
  assign j_contend = j_pend_reg | bus.jtag_req;
  assign j_clr     = ((state_reg == J_ACC) && hold_wr_reg) || (state_reg == J_RD);
  assign j_accept  = bus.jtag_req && (!j_pend_reg || j_clr);
  assign j_drop    = bus.jtag_req && j_pend_reg && !j_clr;

  always_comb begin
    state_next      = state_reg;
    grant_j         = 1'b0;
    grant_a         = 1'b0;
    ram_addr_sel    = '0;
    ram_wdata_sel   = '0;
    ram_we_sel      = 1'b0;
    ram_re_sel      = 1'b0;
    waitrequest_sel = 1'b1;
    case (state_reg)
      IDLE: begin
        if (j_contend && (!a_pend || !last_grant_j_reg)) begin
          if (j_pend_reg) begin
            state_next = J_ACC;
            grant_j    = 1'b1;
          end
        end else if (a_pend) begin
          state_next = A_ACC;
          grant_a    = 1'b1;
        end
      end
      J_ACC: begin
        ram_addr_sel  = hold_addr_reg;
        ram_wdata_sel = hold_wdata_reg;
        ram_we_sel    = hold_wr_reg;
        ram_re_sel    = !hold_wr_reg;
        state_next    = hold_wr_reg ? IDLE : J_RD;
      end
      J_RD: begin
        state_next = IDLE;
      end
      A_ACC: begin
        ram_addr_sel  = bus.avs_address;
        ram_wdata_sel = bus.avs_writedata;
        if (bus.avs_write) begin
          ram_we_sel      = 1'b1;
          waitrequest_sel = 1'b0;
          state_next      = IDLE;
        end else begin
          ram_re_sel = 1'b1;
          state_next = A_RD;
        end
      end
      A_RD: begin
        waitrequest_sel = 1'b0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      j_pend_reg       <= 1'b0;
      hold_wr_reg      <= 1'b0;
      hold_addr_reg    <= '0;
      hold_wdata_reg   <= '0;
      last_grant_j_reg <= 1'b0;
      jtag_rdata_reg   <= '0;
      rdata_valid_reg  <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (j_accept) begin
        j_pend_reg     <= 1'b1;
        hold_wr_reg    <= bus.jtag_wr;
        hold_addr_reg  <= bus.jtag_addr;
        hold_wdata_reg <= bus.jtag_wdata;
      end else if (j_clr) begin
        j_pend_reg <= 1'b0;
      end
      if (grant_j) begin
        last_grant_j_reg <= 1'b1;
      end else if (grant_a) begin
        last_grant_j_reg <= 1'b0;
      end
      if (j_drop) begin
        overrun_reg <= 1'b1;
      end else if (bus.clear_overrun) begin
        overrun_reg <= 1'b0;
      end
      rdata_valid_reg <= (state_reg == J_RD);
      if (state_reg == J_RD) begin
        jtag_rdata_reg <= bus.ram_rdata;
      end
    end
  end

  assign bus.ram_addr         = ram_addr_sel;
  assign bus.ram_wdata        = ram_wdata_sel;
  assign bus.ram_we           = ram_we_sel;
  assign bus.ram_re           = ram_re_sel;
  assign bus.avs_waitrequest  = waitrequest_sel;
  assign bus.avs_readdata     = bus.ram_rdata;
  assign bus.jtag_rdata       = jtag_rdata_reg;
  assign bus.jtag_rdata_valid = rdata_valid_reg;
  assign bus.jtag_overrun     = overrun_reg;

endmodule

// File: doc/ocimem_access_arbiter.md
Name: ocimem_access_arbiter

Overview:
- Clk-domain arbiter that shares the single-port on-chip debug memory (OCI RAM) between two requesters.
- Requester J: the JTAG debug slave path; single-cycle take_action strobes carry decoded jdo fields.
- Requester A: an Avalon-MM debug-port slave used by the CPU/host side.
- Sequences each access through a small FSM, returns read data to the correct requester and applies round-robin fairness when both contend.

Parameters:
- ADDR_W, 8, OCI RAM word address width.
- DATA_W, 32, OCI RAM data width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jtag_req  in  1  single-cycle request pulse from the JTAG sysclk path.
- jtag_wr  in  1  1 = write, 0 = read; sampled with jtag_req.
- jtag_addr  in  ADDR_W  word address; sampled with jtag_req.
- jtag_wdata  in  DATA_W  write data; sampled with jtag_req.
- jtag_rdata  out  DATA_W  registered read data for J.
- jtag_rdata_valid  out  1  one-cycle pulse; jtag_rdata is valid.
- jtag_overrun  out  1  sticky flag; a J request was dropped.
- clear_overrun  in  1  clears jtag_overrun.
- avs_address  in  ADDR_W  Avalon word address.
- avs_read  in  1  Avalon read.
- avs_write  in  1  Avalon write.
- avs_writedata  in  DATA_W  Avalon write data.
- avs_readdata  out  DATA_W  Avalon read data; equals ram_rdata.
- avs_waitrequest  out  1  Avalon stall.
- ram_addr  out  ADDR_W  OCI RAM address.
- ram_wdata  out  DATA_W  OCI RAM write data.
- ram_we  out  1  OCI RAM write enable.
- ram_re  out  1  OCI RAM read enable.
- ram_rdata  in  DATA_W  OCI RAM read data; valid the cycle after ram_re.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous assert, active low. The reset deassertion is synchronised upstream.
- Reset state:
  - FSM = IDLE.
  - J holding register empty; jtag_rdata = 0; jtag_rdata_valid = 0; jtag_overrun = 0.
  - last_grant = A, so J wins the first tie.
  - ram_we = ram_re = 0; avs_waitrequest = 1.
  - Reset mid-access abandons the access; no completion is signalled to either side.
- J capture:
  - A jtag_req pulse loads a 1-deep holding register (wr, addr, wdata) and sets j_pend.
  - If jtag_req arrives while j_pend = 1 and j_pend is not being cleared that cycle, the request is dropped and jtag_overrun is set.
  - A pulse in the same cycle j_pend clears is accepted, with no overrun.
  - If set and clear_overrun occur together, set wins.
- Avalon request:
  - a_pend = avs_read | avs_write.
  - Master holds inputs stable while avs_waitrequest = 1.
  - If both read and write are asserted, it is treated as a write.
- FSM states: IDLE, J_ACC, J_RD, A_ACC, A_RD.
- IDLE:
  - ram strobes are 0; avs_waitrequest = 1.
  - Only j_pend -> J_ACC. Only a_pend -> A_ACC.
  - Both pending -> grant the requester that is not last_grant.
  - The granted requester is recorded in last_grant.
- J_ACC:
  - Drive ram_addr/ram_wdata from the holding register; ram_we = wr, ram_re = ~wr.
  - Write -> clear j_pend, go to IDLE.
  - Read -> J_RD.
- J_RD:
  - Register ram_rdata into jtag_rdata and clear j_pend.
  - jtag_rdata_valid is 1 in the following cycle, for exactly 1 cycle.
  - -> IDLE.
- A_ACC:
  - Drive ram_addr/ram_wdata from avs_address/avs_writedata.
  - Write: ram_we = 1 and avs_waitrequest = 0 (accept), -> IDLE.
  - Read: ram_re = 1, avs_waitrequest = 1, -> A_RD.
- A_RD: avs_waitrequest = 0; avs_readdata = ram_rdata; -> IDLE.
- Outputs:
  - ram_* and avs_waitrequest are combinational from state and registers.
  - avs_readdata is ram_rdata passed through.
  - ram_addr/ram_wdata are 0 in IDLE.
- Latency (pulse or request at cycle 0):
  - J write: ram_we at cycle 2.
  - J read: ram_re at cycle 2, jtag_rdata_valid at cycle 4.
  - A write: accepted at cycle 1.
  - A read: data with waitrequest = 0 at cycle 2.
- Every access returns to IDLE, so there is one arbitration cycle between back-to-back accesses.
- Worst-case wait for either requester is one opposing access.

Test Plan:
- After reset: avs_waitrequest = 1, ram_we = ram_re = 0, jtag_overrun = 0. Then jtag_req with wr = 1, addr = 0x10, wdata = 0xDEADBEEF at cycle 0 -> ram_we = 1 with addr 0x10 and data 0xDEADBEEF exactly at cycle 2.
- J read of addr 0x10 with ram model returning 0xDEADBEEF -> ram_re at cycle 2; jtag_rdata = 0xDEADBEEF with jtag_rdata_valid high only in cycle 4.
- Avalon read of addr 0x20 (model data 0x12345678) -> avs_waitrequest low only in cycle 2 with avs_readdata = 0x12345678. Avalon write -> waitrequest low in cycle 1, ram_we = 1 that cycle.
- jtag_req and avs_write both arrive in cycle 0 from reset -> J served first (J_ACC cycle 2), A_ACC at cycle 4. Repeat both with continuous pressure -> grants alternate J, A, J, A.
- Second jtag_req while a J read is pending in J_ACC -> dropped, jtag_overrun = 1 and sticky. clear_overrun pulse -> 0. Set and clear in the same cycle -> stays 1.
- Assert reset_n low during A_RD -> immediately avs_waitrequest = 1, ram strobes 0, FSM IDLE, j_pend cleared; no jtag_rdata_valid pulse after release.
